// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg
//   Shared definitions for the 5-stage RV64 pipeline control slice:
//   the hazard-controller FSM state type, the x0 register index and
//   the default watchdog limit for wait episodes.
package rv_pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MC_WAIT  = 2'd1,
      MEM_WAIT = 2'd2
   } ctrl_state_e;

   localparam logic [4:0]  REG_X0           = 5'd0;
   localparam int unsigned WAIT_TIMEOUT_DEF = 1024;

   function automatic logic is_wait(input ctrl_state_e s);
      return (s == MC_WAIT) || (s == MEM_WAIT);
   endfunction

endpackage

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer
//   Watchdog for wait episodes. The count clears at the start of an
//   episode and advances on every wait cycle; reaching LIMIT sets a
//   sticky error flag that only reset clears.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : a new wait episode starts this cycle
//   inc_i      : this cycle is a wait cycle
//   err_o      : sticky timeout flag
module pipe_wait_timer
   import rv_pipe_pkg::*;
#(
   parameter int unsigned LIMIT = WAIT_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic err_o
);

   localparam int unsigned W       = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;
   logic         err_q, err_d;

   // Saturates at LIMIT so a long-stuck wait cannot wrap the count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIMIT_C)) begin
         cnt_d = cnt_q + W'(1);
      end
      err_d = err_q | (cnt_d == LIMIT_C);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hold/flush control for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers of the 5-stage RV64 core. Resolves memory wait states,
//   multi-cycle EX ops, EX redirects and load-use hazards, in that
//   priority, plus a wait watchdog and stall/flush counters.
// Ports:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source registers and usage
//   ex_rd, ex_MemRead                    : EX destination / EX is a load
//   ex_redirect                          : taken branch/jump in EX
//   ex_mc_start, mc_done, mc_go          : multi-cycle unit handshake
//   mem_req, dmem_ready                  : MEM stage access / completion
//   pc_en .. exmem_en                    : register load enables
//   ifid_flush, idex_flush               : NOP bubble insertion
//   exmem_bubble, memwb_bubble           : bubble into EX/MEM, MEM/WB
//   ctrl_state                           : FSM state
//   stall_cnt, flush_cnt                 : wrapping performance counters
//   timeout_err                          : sticky watchdog flag
module pipe_hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_MemRead,
   input  logic             ex_redirect,
   input  logic             ex_mc_start,
   input  logic             mc_done,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             mc_go,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_bubble,
   output logic             memwb_bubble,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             timeout_err
);

   ctrl_state_e      state_q, state_d, eff_st;
   logic             resume_q, resume_d;
   logic             done_q, done_d;
   logic             lu, mw, mc_done_eff, flush_inc;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             wd_clr, wd_inc;

   assign lu = ex_MemRead && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
   assign mw = mem_req && !dmem_ready;

   // MEM_WAIT remembers which state it interrupted; once the memory
   // stall releases, the rules of that state apply.
   assign eff_st      = (state_q == MEM_WAIT) ? (resume_q ? MC_WAIT : RUN) : state_q;
   assign mc_done_eff = mc_done || done_q;

   always_comb begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      mc_go        = 1'b0;
      flush_inc    = 1'b0;
      state_d      = state_q;
      resume_d     = resume_q;
      done_d       = done_q;
      if (!reset) begin
         if (mw) begin
            memwb_bubble = 1'b1;
            state_d      = MEM_WAIT;
            resume_d     = (eff_st == MC_WAIT);
            // An mc_done seen while memory-stalled must not be lost.
            done_d       = (eff_st == MC_WAIT) && mc_done_eff;
         end else begin
            resume_d = 1'b0;
            done_d   = 1'b0;
            if (((eff_st == RUN) && ex_mc_start) ||
                ((eff_st == MC_WAIT) && !mc_done_eff)) begin
               exmem_en     = 1'b1;
               exmem_bubble = 1'b1;
               mc_go        = (eff_st == RUN);
               state_d      = MC_WAIT;
            end else begin
               state_d = RUN;
               if (ex_redirect) begin
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  flush_inc  = 1'b1;
               end else if (lu) begin
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  idex_flush = 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         resume_q    <= 1'b0;
         done_q      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         done_q   <= done_d;
         if (!pc_en) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_inc) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign wd_clr = (state_d != state_q) && is_wait(state_d);
   assign wd_inc = is_wait(state_q);

   pipe_wait_timer #(
      .LIMIT (WAIT_TIMEOUT)
   ) u_wait_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i (wd_clr),
      .inc_i (wd_inc),
      .err_o (timeout_err)
   );

   assign ctrl_state = state_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   localparam int unsigned TMO  = 16;
   localparam int unsigned CW   = 8;
   localparam int          CMSK = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_MemRead, ex_redirect;
   logic          ex_mc_start, mc_done, mem_req, dmem_ready;
   logic          mc_go, pc_en, ifid_en, idex_en, exmem_en;
   logic          ifid_flush, idex_flush, exmem_bubble, memwb_bubble;
   logic [1:0]    ctrl_state;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic          timeout_err;

   int tests  = 0;
   int failed = 0;

   // Reference model: tracks whether a multi-cycle op is outstanding,
   // whether its result already arrived, and whether memory held us.
   bit m_mc_active, m_done_seen, m_in_mem, m_tmo;
   int m_wcnt, m_stall, m_flush;

   pipe_hazard_ctrl #(
      .WAIT_TIMEOUT (TMO),
      .CNT_W        (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_MemRead   (ex_MemRead),
      .ex_redirect  (ex_redirect),
      .ex_mc_start  (ex_mc_start),
      .mc_done      (mc_done),
      .mem_req      (mem_req),
      .dmem_ready   (dmem_ready),
      .mc_go        (mc_go),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .exmem_bubble (exmem_bubble),
      .memwb_bubble (memwb_bubble),
      .ctrl_state   (ctrl_state),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_MemRead = 1'b0;
      ex_redirect = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
      mem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   function automatic int m_state();
      return m_in_mem ? 2 : (m_mc_active ? 1 : 0);
   endfunction

   task automatic chk_regs();
      chk("state",   32'(ctrl_state),  32'(m_state()));
      chk("stall",   32'(stall_cnt),   32'(m_stall));
      chk("flush",   32'(flush_cnt),   32'(m_flush));
      chk("timeout", 32'(timeout_err), 32'(m_tmo));
   endtask

   // Asynchronous reset applied away from the clock edge; it must act at once.
   task automatic do_reset();
      idle();
      reset = 1'b1;
      #1;
      m_mc_active = 0; m_done_seen = 0; m_in_mem = 0; m_tmo = 0;
      m_wcnt = 0; m_stall = 0; m_flush = 0;
      chk("rst_pc_en",   32'(pc_en),   0);
      chk("rst_ifid_en", 32'(ifid_en), 0);
      chk("rst_idex_en", 32'(idex_en), 0);
      chk("rst_exmem",   32'(exmem_en), 0);
      chk("rst_mwb",     32'(memwb_bubble), 0);
      chk("rst_mc_go",   32'(mc_go), 0);
      chk_regs();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic tick();
      bit mw, lu;
      bit e_pc, e_ifid, e_idex, e_exm, e_iff, e_idf, e_exb, e_mwb, e_go;
      int cur, nxt;
      mw  = mem_req && !dmem_ready;
      lu  = ex_MemRead && (ex_rd != 0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      cur = m_state();
      {e_pc, e_ifid, e_idex, e_exm, e_iff, e_idf, e_exb, e_mwb, e_go} = '0;
      if (mw) begin
         e_mwb = 1;
         if (m_mc_active && mc_done) m_done_seen = 1;
         m_in_mem = 1;
      end else begin
         m_in_mem = 0;
         if (!m_mc_active && ex_mc_start) begin
            e_go = 1; e_exm = 1; e_exb = 1; m_mc_active = 1;
         end else if (m_mc_active && !(mc_done || m_done_seen)) begin
            e_exm = 1; e_exb = 1;
         end else begin
            m_mc_active = 0; m_done_seen = 0;
            if (ex_redirect) begin
               {e_pc, e_ifid, e_idex, e_exm, e_iff, e_idf} = '1;
               m_flush = (m_flush + 1) & CMSK;
            end else if (lu) begin
               e_idex = 1; e_exm = 1; e_idf = 1;
            end else begin
               {e_pc, e_ifid, e_idex, e_exm} = '1;
            end
         end
      end
      if (!e_pc) m_stall = (m_stall + 1) & CMSK;
      nxt = m_state();
      if (nxt != 0 && nxt != cur) m_wcnt = 0;
      else if (cur != 0) begin
         m_wcnt++;
         if (m_wcnt >= int'(TMO)) m_tmo = 1;
      end
      @(negedge clk);
      chk("pc_en",        32'(pc_en),        32'(e_pc));
      chk("ifid_en",      32'(ifid_en),      32'(e_ifid));
      chk("idex_en",      32'(idex_en),      32'(e_idex));
      chk("exmem_en",     32'(exmem_en),     32'(e_exm));
      chk("ifid_flush",   32'(ifid_flush),   32'(e_iff));
      chk("idex_flush",   32'(idex_flush),   32'(e_idf));
      chk("exmem_bubble", 32'(exmem_bubble), 32'(e_exb));
      chk("memwb_bubble", 32'(memwb_bubble), 32'(e_mwb));
      chk("mc_go",        32'(mc_go),        32'(e_go));
      @(posedge clk); #1;
      chk_regs();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #2;
      do_reset();

      // Load-use on rs2: one bubble.
      ex_MemRead = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
      tick();
      chk("lu_stall_cnt", 32'(stall_cnt), 1);
      idle(); tick();

      // Load to x0 never stalls.
      do_reset();
      ex_MemRead = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
      tick();
      chk("x0_stall_cnt", 32'(stall_cnt), 0);

      // Redirect beats load-use.
      do_reset();
      ex_MemRead = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1; ex_redirect = 1;
      tick();
      chk("redir_flush_cnt", 32'(flush_cnt), 1);
      idle(); tick();

      // Multi-cycle op of 8 cycles.
      do_reset();
      ex_mc_start = 1; tick();
      ex_mc_start = 0;
      for (int i = 0; i < 7; i++) tick();
      mc_done = 1; tick();
      chk("mc_stall_cnt", 32'(stall_cnt), 8);
      chk("mc_state_run", 32'(ctrl_state), 0);
      idle(); tick();

      // Memory wait interrupting MC_WAIT, mc_done arriving inside it.
      do_reset();
      ex_mc_start = 1; tick();
      ex_mc_start = 0; tick(); tick();
      for (int i = 0; i < 4; i++) begin
         mem_req = 1; dmem_ready = 0; mc_done = (i == 1);
         tick();
      end
      mc_done = 0; mem_req = 1; dmem_ready = 1; tick();
      chk("mcmw_state_run", 32'(ctrl_state), 0);
      idle(); tick();

      // Watchdog: MEM_WAIT held, then reset mid-wait.
      do_reset();
      mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 16; i++) tick();
      chk("wd_not_yet", 32'(timeout_err), 0);
      tick();
      chk("wd_set",       32'(timeout_err), 1);
      chk("wd_state_mem", 32'(ctrl_state), 2);
      tick();
      do_reset();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 2000; n++) begin
         if (n % 500 == 499) do_reset();
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         ex_rd       = 5'($urandom_range(0, 3));
         id_use_rs1  = ($urandom_range(0, 99) < 60);
         id_use_rs2  = ($urandom_range(0, 99) < 60);
         ex_MemRead  = ($urandom_range(0, 99) < 40);
         ex_redirect = ($urandom_range(0, 99) < 15);
         ex_mc_start = ($urandom_range(0, 99) < 10);
         mc_done     = ($urandom_range(0, 99) < 20);
         mem_req     = ($urandom_range(0, 99) < 30);
         dmem_ready  = ($urandom_range(0, 99) < 60);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
